// File: rtl/tone_generator.sv
// -----------------------------------------------------------------------------
// tone_generator
//
// Square-wave note generator. A half-period counter runs from 0 up to an
// active limit, and on reaching it wraps to 0 and inverts tone_out. The limit
// comes from a fixed table of base half-periods (one per note of the scale),
// shifted right by the octave select.
//
// Note changes go through a one-deep pending register. A request is taken
// when note_vld and note_rdy are both high. While the tone is running, the
// pending note is applied only at a half-period boundary, so the waveform
// never has a truncated half-period. While the tone is disabled, it is
// applied on the next cycle.
//
// Parameters
//   CNT_W    : half-period counter width (16..32)
//   OCT_W    : octave-select width; octave shift range is 0..2**OCT_W-1
//   IDLE_LVL : tone_out level while disabled or in reset
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   en       : tone generation enable
//   note_vld : note change request
//   note     : requested note index (0=do .. 6=si, 7=do2)
//   octave   : requested octave shift
//   note_rdy : high when a request can be accepted
//   tone_out : square-wave output
//   edge_stb : one-cycle pulse aligned with each new tone_out value
//   act_note : note currently sounding
//   act_oct  : octave currently sounding
// -----------------------------------------------------------------------------
module tone_generator #(
  parameter int   CNT_W    = 16,
  parameter int   OCT_W    = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             note_vld,
  input  logic [2:0]       note,
  input  logic [OCT_W-1:0] octave,
  output logic             note_rdy,
  output logic             tone_out,
  output logic             edge_stb,
  output logic [2:0]       act_note,
  output logic [OCT_W-1:0] act_oct
);

  if (CNT_W < 16 || CNT_W > 32) begin : g_bad_cnt_w
    $error("tone_generator: CNT_W must be in 16..32");
  end

  // Base half-period limits in clk cycles minus one, one per note.
  function automatic logic [15:0] base_lim(input logic [2:0] idx);
    logic [15:0] lim;
    case (idx)
      3'd0:    lim = 16'd47820;
      3'd1:    lim = 16'd42645;
      3'd2:    lim = 16'd37936;
      3'd3:    lim = 16'd35831;
      3'd4:    lim = 16'd31924;
      3'd5:    lim = 16'd28409;
      3'd6:    lim = 16'd25341;
      default: lim = 16'd23907;
    endcase
    return lim;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;
  logic             at_lim;
  logic             accept;
  logic             apply;

  logic             pend_vld;
  logic [2:0]       pend_note;
  logic [OCT_W-1:0] pend_oct;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here the first statement) so no latch is inferred.
  always_comb begin
    limit  = '0;
    limit  = CNT_W'(base_lim(act_note) >> act_oct);
    at_lim = (cnt == limit);
  end

  // The pending slot is the only buffering; while it is full, requests are
  // dropped rather than queued.
  assign note_rdy = ~pend_vld;
  assign accept   = note_vld & note_rdy;

  // A pending note only exists from the cycle after its acceptance, so a
  // request taken on a boundary edge cannot be applied at that same edge.
  assign apply    = pend_vld & (~en | at_lim);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      tone_out  <= IDLE_LVL;
      edge_stb  <= 1'b0;
      act_note  <= '0;
      act_oct   <= '0;
      pend_vld  <= 1'b0;
      pend_note <= '0;
      pend_oct  <= '0;
    end else begin
      edge_stb <= 1'b0;

      // Disabled: park the counter so the next enable starts a full
      // half-period at the idle level.
      if (!en) begin
        cnt      <= '0;
        tone_out <= IDLE_LVL;
      end else if (at_lim) begin
        cnt      <= '0;
        tone_out <= ~tone_out;
        edge_stb <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // apply and accept are mutually exclusive: accept needs an empty slot.
      if (apply) begin
        act_note <= pend_note;
        act_oct  <= pend_oct;
        pend_vld <= 1'b0;
      end else if (accept) begin
        pend_vld  <= 1'b1;
        pend_note <= note;
        pend_oct  <= octave;
      end
    end
  end

endmodule

// File: tb/tb_tone_generator.sv
// -----------------------------------------------------------------------------
// tb_tone_generator
//
// Self-checking bench for tone_generator. The reference model tracks the
// sounding note, the pending request and the absolute cycle of the next
// tone_out toggle. Whenever stimulus commits to a request or a wait, the
// toggles that must occur are pushed into a scoreboard; a monitor pops one
// entry per edge_stb pulse and compares the toggle cycle, new level and
// reported note/octave.
// Cycle numbering: cyc is the index of the most recent rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tone_generator;

  localparam int   CNT_W = 16;
  localparam int   OCT_W = 3;
  localparam logic IDLE  = 1'b0;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             note_vld;
  logic [2:0]       note;
  logic [OCT_W-1:0] octave;
  logic             note_rdy;
  logic             tone_out;
  logic             edge_stb;
  logic [2:0]       act_note;
  logic [OCT_W-1:0] act_oct;

  tone_generator #(
    .CNT_W   (CNT_W),
    .OCT_W   (OCT_W),
    .IDLE_LVL(IDLE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .note_vld(note_vld),
    .note    (note),
    .octave  (octave),
    .note_rdy(note_rdy),
    .tone_out(tone_out),
    .edge_stb(edge_stb),
    .act_note(act_note),
    .act_oct (act_oct)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               tgl_cyc;
    logic             lvl;
    logic [2:0]       note;
    logic [OCT_W-1:0] oct;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model state
  logic             m_en;
  logic             m_lvl;
  logic [2:0]       m_note;
  logic [OCT_W-1:0] m_oct;
  int               m_end;
  logic             m_pend;
  logic [2:0]       p_note;
  logic [OCT_W-1:0] p_oct;
  int               p_cyc;

  // Half-period length in cycles for a note/octave pair.
  function automatic int half_len(input logic [2:0] n, input logic [OCT_W-1:0] o);
    int base [8] = '{47820, 42645, 37936, 35831, 31924, 28409, 25341, 23907};
    return (base[n] >> o) + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  // Commit the next toggle to the scoreboard. A pending note accepted
  // strictly before this boundary takes effect at it.
  task automatic push_next();
    exp_t e;
    if (m_pend && p_cyc < m_end) begin
      m_note = p_note;
      m_oct  = p_oct;
      m_pend = 1'b0;
    end
    m_lvl     = ~m_lvl;
    e.tgl_cyc = m_end;
    e.lvl     = m_lvl;
    e.note    = m_note;
    e.oct     = m_oct;
    sb.push_back(e);
    m_end += half_len(m_note, m_oct);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cycles(input int n);
    if (m_en) while (m_end <= cyc + n) push_next();
    step(n);
  endtask

  task automatic en_on();
    m_en  = 1'b1;
    m_lvl = IDLE;
    m_end = cyc + half_len(m_note, m_oct);
    en    = 1'b1;
  endtask

  task automatic en_off();
    en   = 1'b0;
    m_en = 1'b0;
    step(2);
    check("tone_idle", 32'(tone_out), 32'(IDLE));
    check("edge_stb_idle", 32'(edge_stb), 32'd0);
  endtask

  // Issue a request on the next edge; app returns the cycle it takes effect.
  task automatic request(input logic [2:0] n, input logic [OCT_W-1:0] o, output int app);
    int a;
    check("note_rdy_free", 32'(note_rdy), 32'd1);
    a = cyc + 1;
    if (m_en) begin
      while (m_end <= a) push_next();
      m_pend = 1'b1;
      p_note = n;
      p_oct  = o;
      p_cyc  = a;
      app    = m_end;
      push_next();
    end else begin
      m_note = n;
      m_oct  = o;
      app    = a + 1;
    end
    note_vld = 1'b1;
    note     = n;
    octave   = o;
    step(1);
    note_vld = 1'b0;
    check("note_rdy_accepted", 32'(note_rdy), 32'd0);
  endtask

  // A request while busy must be ignored.
  task automatic poke();
    check("note_rdy_busy", 32'(note_rdy), 32'd0);
    note_vld = 1'b1;
    note     = 3'($urandom);
    octave   = OCT_W'($urandom);
    step(1);
    note_vld = 1'b0;
  endtask

  task automatic wait_apply(input int app);
    while (cyc < app) begin
      if ($urandom_range(0, 99) == 0) poke();
      else step(1);
    end
    check("note_rdy_released", 32'(note_rdy), 32'd1);
    check("act_note_applied", 32'(act_note), 32'(m_note));
    check("act_oct_applied", 32'(act_oct), 32'(m_oct));
  endtask

  // Monitor: one scoreboard entry per edge_stb pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && edge_stb === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_edge_stb at cycle %0d: got a toggle, required none", cyc);
        end else begin
          e = sb.pop_front();
          check("toggle_cycle", cyc, e.tgl_cyc);
          check("toggle_level", 32'(tone_out), 32'(e.lvl));
          check("toggle_note", 32'(act_note), 32'(e.note));
          check("toggle_oct", 32'(act_oct), 32'(e.oct));
        end
      end
    end
  end

  initial begin : stim
    int app;
    int missed;
    exp_t e;

    rst_n    = 1'b0;
    en       = 1'b0;
    note_vld = 1'b0;
    note     = '0;
    octave   = '0;
    m_en     = 1'b0;
    m_lvl    = IDLE;
    m_note   = '0;
    m_oct    = '0;
    m_end    = 0;
    m_pend   = 1'b0;
    p_note   = '0;
    p_oct    = '0;
    p_cyc    = 0;

    step(3);
    check("rst_tone", 32'(tone_out), 32'(IDLE));
    check("rst_edge_stb", 32'(edge_stb), 32'd0);
    check("rst_act_note", 32'(act_note), 32'd0);
    check("rst_act_oct", 32'(act_oct), 32'd0);
    check("rst_note_rdy", 32'(note_rdy), 32'd1);
    rst_n = 1'b1;
    step(5);
    check("idle_tone", 32'(tone_out), 32'(IDLE));

    // Default note 0 octave 0; request note 7 at count 100 of the first
    // half-period, with a second request ignored during the wait.
    en_on();
    wait_cycles(100);
    request(3'd7, 3'd3, app);
    poke();
    wait_apply(app);
    wait_cycles(half_len(3'd7, 3'd3) + 3);
    en_off();

    // Requests while disabled apply on the cycle after acceptance.
    request(3'd5, 3'd2, app);
    wait_apply(app);
    en_on();
    wait_cycles(half_len(3'd5, 3'd2) + 3);
    en_off();
    request(3'd0, 3'd3, app);
    wait_apply(app);
    en_on();
    wait_cycles(half_len(3'd0, 3'd3) + 3);
    en_off();
    request(3'd2, 3'd7, app);
    wait_apply(app);
    en_on();

    // Request coincident with a boundary: one more old half-period.
    wait_cycles(m_end - cyc - 1);
    request(3'($urandom), OCT_W'($urandom_range(6, 7)), app);
    wait_apply(app);

    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) wait_cycles(m_end - cyc - 1);
      else wait_cycles($urandom_range(0, 300));
      request(3'($urandom), OCT_W'($urandom_range(6, 7)), app);
      wait_apply(app);
    end

    // Reset mid-half-period with a request pending.
    wait_cycles(m_end - cyc);
    request(3'd3, 3'd6, app);
    step(40);
    #4 rst_n = 1'b0;
    #1;
    check("arst_tone", 32'(tone_out), 32'(IDLE));
    check("arst_edge_stb", 32'(edge_stb), 32'd0);
    check("arst_act_note", 32'(act_note), 32'd0);
    check("arst_act_oct", 32'(act_oct), 32'd0);
    check("arst_note_rdy", 32'(note_rdy), 32'd1);
    missed = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.tgl_cyc <= cyc) missed++;
    end
    check("toggles_before_reset", missed, 0);
    en     = 1'b0;
    m_en   = 1'b0;
    m_lvl  = IDLE;
    m_note = '0;
    m_oct  = '0;
    m_pend = 1'b0;
    step(3);
    rst_n = 1'b1;
    check("restart_act_note", 32'(act_note), 32'd0);
    check("restart_act_oct", 32'(act_oct), 32'd0);
    request(3'd6, 3'd7, app);
    wait_apply(app);
    en_on();
    wait_cycles(2 * half_len(3'd6, 3'd7) + 3);
    en_off();

    step(5);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_generator.md
TONE_GENERATOR -- requirements
Module: tone_generator

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the half-period counter width; legal range 16..32.
REQ-002 Parameter OCT_W, default 2, SHALL set the octave-select width; octave shift range is 0..2^OCT_W-1.
REQ-003 Parameter IDLE_LVL, default 0, SHALL set the tone_out level while disabled.
REQ-004 clk  input  1  SHALL be the single system clock (50 MHz nominal); all logic on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 en  input  1  SHALL enable tone generation when high.
REQ-007 note_vld  input  1  SHALL request a note change.
REQ-008 note  input  3  SHALL give the requested note index: 0=do, 1=re, 2=mi, 3=fa, 4=so, 5=la, 6=si, 7=do2.
REQ-009 octave  input  OCT_W  SHALL give the requested octave shift.
REQ-010 note_rdy  output  1  SHALL be high when a request can be accepted.
REQ-011 tone_out  output  1  SHALL carry the square-wave tone.
REQ-012 edge_stb  output  1  SHALL pulse for one cycle on every tone_out toggle.
REQ-013 act_note  output  3  SHALL report the note currently sounding.
REQ-014 act_oct  output  OCT_W  SHALL report the octave currently sounding.

Function
REQ-015 Base half-period limits SHALL be fixed constants: 47820, 42645, 37936, 35831, 31924, 28409, 25341, 23907 for notes 0..7.
REQ-016 Active limit SHALL be base[act_note] logically shifted right by act_oct, zero-extended to CNT_W.
REQ-017 Each half-period SHALL last limit+1 clk cycles: count increments from 0; when count==limit, count goes to 0 and tone_out inverts in the same cycle.
REQ-018 edge_stb SHALL be high in the cycle immediately after each tone_out inversion, aligned with the new tone_out value.
REQ-019 A request SHALL be accepted on a rising clk edge where note_vld and note_rdy are both high; note and octave are then captured into a pending register.
REQ-020 note_rdy SHALL be low from the cycle after acceptance until the pending value is applied; it SHALL be high otherwise.
REQ-021 While en is high, the pending value SHALL be applied only at the first half-period boundary (count==limit) strictly after the acceptance cycle. act_note, act_oct and the limit change together, so no half-period is truncated.
REQ-022 While en is low, a pending value SHALL be applied on the cycle after acceptance.
REQ-023 A request accepted in the same cycle as a boundary SHALL NOT apply at that boundary; it applies at the next one.
REQ-024 While en is low, count SHALL be held at 0, tone_out SHALL equal IDLE_LVL, and edge_stb SHALL be 0.
REQ-025 On an en rising edge, counting SHALL start from 0 using the current active limit, with tone_out starting at IDLE_LVL.
REQ-026 note_vld while note_rdy is low SHALL be ignored; no queueing beyond one pending entry.

Reset
REQ-027 Asserting rst_n low SHALL immediately clear: count=0, tone_out=IDLE_LVL, edge_stb=0, act_note=0, act_oct=0, pending cleared, note_rdy=1.
REQ-028 Reset asserted mid-period SHALL discard any pending request.
REQ-029 After rst_n deasserts, the first accept or count SHALL occur on the first clk edge following deassertion.

Verification
REQ-030 Reset, then en=1 with no request -> tone_out toggles every 47821 cycles; edge_stb pulses once per toggle.
REQ-031 Request note=5, octave=0, en=0, then en=1 -> half-period of 28410 cycles; act_note=5.
REQ-032 Request note=0, octave=1 -> half-period of 23911 cycles; octave=3 -> 5978 cycles.
REQ-033 Request note=7 at count=100 of a note-0 half-period -> that half-period completes at 47821 cycles; next half-period is 23908; note_rdy is low throughout the wait; a second note_vld during the wait is ignored.
REQ-034 Request coincident with count==limit -> one more full old half-period elapses before the new limit takes effect.
REQ-035 rst_n pulsed low mid-half-period with a request pending -> outputs match REQ-027 asynchronously; restart uses note 0, octave 0.
